// File: rtl/otter_mem_pipe_bram_pkg.sv
// Shared types and helpers for the OTTER pipelined BRAM: latency bounds,
// byte-select legality and lane merging.
package otter_mem_pkg;

  localparam int MIN_LAT = 1;
  localparam int MAX_LAT = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } mem_rsp_t;

  // 0000 counts as legal: the write is acknowledged but touches no lane.
  function automatic logic sel_legal(input logic [3:0] sel);
    logic ok;
    case (sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/otter_mem_pipe_bram_if.sv
// Fetch and load/store bus between the OTTER core and the pipelined BRAM.
// The core drives the master side, the memory the slave side.
interface otter_mem_pipe_bram_if;

  logic        i_imem_req;
  logic [31:0] i_imem_addr;
  logic        o_imem_ack;
  logic [31:0] o_imem_r_data;
  logic        o_imem_err;

  logic        i_dmem_re;
  logic        i_dmem_we;
  logic [3:0]  i_dmem_sel;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_w_data;
  logic        o_dmem_ack;
  logic [31:0] o_dmem_r_data;
  logic        o_dmem_err;

  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_ack, o_imem_r_data, o_imem_err,
    output i_dmem_re, i_dmem_we, i_dmem_sel, i_dmem_addr, i_dmem_w_data,
    input  o_dmem_ack, o_dmem_r_data, o_dmem_err
  );

  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_ack, o_imem_r_data, o_imem_err,
    input  i_dmem_re, i_dmem_we, i_dmem_sel, i_dmem_addr, i_dmem_w_data,
    output o_dmem_ack, o_dmem_r_data, o_dmem_err
  );

endinterface

// File: rtl/otter_mem_pipe_bram_pipe.sv
// Valid + payload delay line. Only the valid bits are reset, so a flush drops
// in-flight responses while the payload registers stay plain flops.
module otter_mem_pipe #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int DW = DEPTH * WIDTH;

  logic [DEPTH-1:0] valid_q;
  logic [DW-1:0]    data_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= DEPTH'({valid_q, i_valid});
    end
  end

  always_ff @(posedge i_clk) begin
    data_q <= DW'({data_q, i_data});
  end

  assign o_valid = valid_q[DEPTH-1];
  assign o_data  = data_q[DW-1 -: WIDTH];

endmodule

// File: rtl/otter_mem_pipe_bram.sv
// Dual-port unified instruction/data BRAM with READ_LATENCY-cycle responses.
// Optional OTTER_MEM_COLLISION_FWD_EN: forward same-cycle dmem writes to imem reads.
module otter_mem_pipe_bram
  import otter_mem_pkg::*;
#(
  parameter string       ROM_FILE     = "",
  parameter int          BRAM_BYTES   = 65536,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] MEM_BASE     = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  otter_mem_pipe_bram_if.slave  bus
);

  localparam int WORDS = BRAM_BYTES / 4;
  localparam int AW    = $clog2(WORDS);

  if (READ_LATENCY < MIN_LAT || READ_LATENCY > MAX_LAT) begin : g_bad_latency
    $error("otter_mem_pipe_bram: READ_LATENCY %0d outside %0d..%0d",
           READ_LATENCY, MIN_LAT, MAX_LAT);
  end
  if (BRAM_BYTES < 16 || (BRAM_BYTES & (BRAM_BYTES - 1)) != 0) begin : g_bad_size
    $error("otter_mem_pipe_bram: BRAM_BYTES %0d must be a power of two >= 16",
           BRAM_BYTES);
  end

  logic [31:0] mem [WORDS];

  logic [31:0]   i_off, d_off;
  logic          i_oor, d_oor;
  logic [AW-1:0] i_idx, d_idx;
  logic [31:0]   i_word, d_word, i_rd_word;
  logic          d_req, d_conflict, d_sel_ok, d_err, d_wr_en, d_rd_ok;
  mem_rsp_t      i_rsp, d_rsp, i_pipe_q, d_pipe_q;
  logic          i_pipe_v, d_pipe_v;
  logic [31:0]   i_hold_q, d_hold_q;

  // Offsets wrap at 32 bits, so addresses below MEM_BASE land out of range too.
  assign i_off = bus.i_imem_addr - MEM_BASE;
  assign d_off = bus.i_dmem_addr - MEM_BASE;
  assign i_oor = i_off >= 32'(BRAM_BYTES);
  assign d_oor = d_off >= 32'(BRAM_BYTES);
  assign i_idx = i_off[AW+1:2];
  assign d_idx = d_off[AW+1:2];

  assign d_req      = bus.i_dmem_re | bus.i_dmem_we;
  assign d_conflict = bus.i_dmem_re & bus.i_dmem_we;
  assign d_sel_ok   = sel_legal(bus.i_dmem_sel);
  assign d_err      = d_conflict | d_oor | (bus.i_dmem_we & ~d_sel_ok);
  assign d_wr_en    = i_rst_n & bus.i_dmem_we & ~bus.i_dmem_re & ~d_oor & d_sel_ok;
  assign d_rd_ok    = bus.i_dmem_re & ~bus.i_dmem_we & ~d_oor;

  always_ff @(posedge i_clk) begin
    if (d_wr_en) begin
      mem[d_idx] <= lane_merge(mem[d_idx], bus.i_dmem_w_data, bus.i_dmem_sel);
    end
  end

  assign i_word = mem[i_idx];
  assign d_word = mem[d_idx];

`ifdef OTTER_MEM_COLLISION_FWD_EN
  assign i_rd_word = (d_wr_en && !i_oor && (d_idx == i_idx))
                   ? lane_merge(i_word, bus.i_dmem_w_data, bus.i_dmem_sel)
                   : i_word;
`else
  assign i_rd_word = i_word;
`endif

  always_comb begin
    i_rsp      = '0;
    i_rsp.err  = i_oor;
    i_rsp.data = i_oor ? 32'h0 : i_rd_word;
    d_rsp      = '0;
    d_rsp.err  = d_err;
    d_rsp.data = d_rd_ok ? d_word : 32'h0;
  end

  otter_mem_pipe #(
    .WIDTH ($bits(mem_rsp_t)),
    .DEPTH (READ_LATENCY)
  ) u_imem_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (bus.i_imem_req),
    .i_data  (i_rsp),
    .o_valid (i_pipe_v),
    .o_data  (i_pipe_q)
  );

  otter_mem_pipe #(
    .WIDTH ($bits(mem_rsp_t)),
    .DEPTH (READ_LATENCY)
  ) u_dmem_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (d_req),
    .i_data  (d_rsp),
    .o_valid (d_pipe_v),
    .o_data  (d_pipe_q)
  );

  // Read data is presented straight from the pipe on ack and held otherwise;
  // the hold registers give the zero value after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      if (i_pipe_v) i_hold_q <= i_pipe_q.data;
      if (d_pipe_v) d_hold_q <= d_pipe_q.data;
    end
  end

  assign bus.o_imem_ack    = i_pipe_v;
  assign bus.o_imem_err    = i_pipe_v & i_pipe_q.err;
  assign bus.o_imem_r_data = i_pipe_v ? i_pipe_q.data : i_hold_q;
  assign bus.o_dmem_ack    = d_pipe_v;
  assign bus.o_dmem_err    = d_pipe_v & d_pipe_q.err;
  assign bus.o_dmem_r_data = d_pipe_v ? d_pipe_q.data : d_hold_q;

endmodule

// File: tb/tb_otter_mem_pipe_bram.sv
// Scoreboard bench for otter_mem_pipe_bram: READ_LATENCY=3, 1 KiB at 0x1000.
module tb_otter_mem_pipe_bram;
  localparam int LAT = 3;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
    logic        chk;
  } exp_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t i_exp[$], d_exp[$];
  obs_t i_obs[$], d_obs[$];

  otter_mem_pipe_bram_if bus();

  otter_mem_pipe_bram #(
    .ROM_FILE     (""),
    .BRAM_BYTES   (1024),
    .READ_LATENCY (LAT),
    .MEM_BASE     (32'h1000)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.o_imem_ack === 1'b1)
      i_obs.push_back('{err: bus.o_imem_err, data: bus.o_imem_r_data, cyc: cyc});
    if (bus.o_dmem_ack === 1'b1)
      d_obs.push_back('{err: bus.o_dmem_err, data: bus.o_dmem_r_data, cyc: cyc});
  end

  task automatic idle_inputs();
    bus.i_imem_req    = 1'b0;
    bus.i_imem_addr   = 32'h0;
    bus.i_dmem_re     = 1'b0;
    bus.i_dmem_we     = 1'b0;
    bus.i_dmem_sel    = 4'h0;
    bus.i_dmem_addr   = 32'h0;
    bus.i_dmem_w_data = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic imem_rd(input logic [31:0] a, input logic [31:0] d, input logic e);
    bus.i_imem_req  = 1'b1;
    bus.i_imem_addr = a;
    i_exp.push_back('{err: e, data: d, cyc: cyc + 1 + LAT, chk: 1'b1});
  endtask

  task automatic dmem_op(input logic re, input logic we, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] d, input logic e, input logic chk);
    bus.i_dmem_re     = re;
    bus.i_dmem_we     = we;
    bus.i_dmem_sel    = sel;
    bus.i_dmem_addr   = a;
    bus.i_dmem_w_data = wd;
    d_exp.push_back('{err: e, data: d, cyc: cyc + 1 + LAT, chk: chk});
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks += 6;
    if (bus.o_imem_ack !== 1'b0) begin failures++; $display("FAIL reset imem_ack got %b required 0", bus.o_imem_ack); end
    if (bus.o_imem_err !== 1'b0) begin failures++; $display("FAIL reset imem_err got %b required 0", bus.o_imem_err); end
    if (bus.o_imem_r_data !== 32'h0) begin failures++; $display("FAIL reset imem_r_data got %h required 0", bus.o_imem_r_data); end
    if (bus.o_dmem_ack !== 1'b0) begin failures++; $display("FAIL reset dmem_ack got %b required 0", bus.o_dmem_ack); end
    if (bus.o_dmem_err !== 1'b0) begin failures++; $display("FAIL reset dmem_err got %b required 0", bus.o_dmem_err); end
    if (bus.o_dmem_r_data !== 32'h0) begin failures++; $display("FAIL reset dmem_r_data got %h required 0", bus.o_dmem_r_data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    exp_t e;
    obs_t o;
    dmem_op(1'b0, 1'b1, 4'hF, 32'h1040, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1040, 32'hDEADBEEF, 1'b0); tick();
    imem_rd(32'h1043, 32'hDEADBEEF, 1'b0); tick();
    repeat (LAT + 2) tick();
    for (int p = 0; p < 2; p++) begin
      while ((p == 0) ? (i_exp.size() > 0) : (d_exp.size() > 0)) begin
        if (p == 0) e = i_exp.pop_front(); else e = d_exp.pop_front();
        checks++;
        if ((p == 0) ? (i_obs.size() == 0) : (d_obs.size() == 0)) begin
          failures++;
          $display("FAIL latency port%0d ack missing, required cyc=%0d data=%h err=%b", p, e.cyc, e.data, e.err);
        end else begin
          if (p == 0) o = i_obs.pop_front(); else o = d_obs.pop_front();
          if (o.cyc !== e.cyc || o.err !== e.err || (e.chk && o.data !== e.data)) begin
            failures++;
            $display("FAIL latency port%0d got cyc=%0d err=%b data=%h required cyc=%0d err=%b data=%h",
                     p, o.cyc, o.err, o.data, e.cyc, e.err, e.data);
          end
        end
      end
      checks++;
      if ((p == 0) ? (i_obs.size() != 0) : (d_obs.size() != 0)) begin
        failures++;
        $display("FAIL latency port%0d extra acks got %0d required 0", p, (p == 0) ? i_obs.size() : d_obs.size());
        if (p == 0) i_obs.delete(); else d_obs.delete();
      end
    end
  endtask

  task automatic test_byte_write();
    exp_t e;
    obs_t o;
    dmem_op(1'b0, 1'b1, 4'b0010, 32'h1040, 32'h0000AA00, 32'h0, 1'b0, 1'b0); tick();
    dmem_op(1'b1, 1'b0, 4'b0000, 32'h1040, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1); tick();
    dmem_op(1'b0, 1'b1, 4'b0101, 32'h1040, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0); tick();
    dmem_op(1'b0, 1'b1, 4'b0000, 32'h1040, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0); tick();
    dmem_op(1'b1, 1'b0, 4'b0101, 32'h1040, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1); tick();
    repeat (LAT + 2) tick();
    while (d_exp.size() > 0) begin
      e = d_exp.pop_front();
      checks++;
      if (d_obs.size() == 0) begin
        failures++;
        $display("FAIL byte_write ack missing, required cyc=%0d data=%h err=%b", e.cyc, e.data, e.err);
      end else begin
        o = d_obs.pop_front();
        if (o.cyc !== e.cyc || o.err !== e.err || (e.chk && o.data !== e.data)) begin
          failures++;
          $display("FAIL byte_write got cyc=%0d err=%b data=%h required cyc=%0d err=%b data=%h",
                   o.cyc, o.err, o.data, e.cyc, e.err, e.data);
        end
      end
    end
    checks++;
    if (d_obs.size() != 0) begin
      failures++;
      $display("FAIL byte_write extra acks got %0d required 0", d_obs.size());
      d_obs.delete();
    end
    @(negedge clk);
    checks += 2;
    if (bus.o_dmem_ack !== 1'b0) begin failures++; $display("FAIL hold dmem_ack got %b required 0", bus.o_dmem_ack); end
    if (bus.o_dmem_r_data !== 32'hDEADAAEF) begin failures++; $display("FAIL hold dmem_r_data got %h required deadaaef", bus.o_dmem_r_data); end
    tick();
  endtask

  task automatic test_range();
    exp_t e;
    obs_t o;
    dmem_op(1'b0, 1'b1, 4'hF, 32'h1000, 32'h11111111, 32'h0, 1'b0, 1'b0); tick();
    dmem_op(1'b0, 1'b1, 4'hF, 32'h13FC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1400, 32'h0, 1'b1);
    dmem_op(1'b0, 1'b1, 4'hF, 32'h1400, 32'h99999999, 32'h0, 1'b1, 1'b1); tick();
    imem_rd(32'h13FC, 32'hCAFEF00D, 1'b0);
    dmem_op(1'b1, 1'b0, 4'h0, 32'h0FFC, 32'h0, 32'h0, 1'b1, 1'b1); tick();
    imem_rd(32'hFFFFFFFC, 32'h0, 1'b1);
    dmem_op(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, 32'h11111111, 1'b0, 1'b1); tick();
    imem_rd(32'h0000_0000, 32'h0, 1'b1); tick();
    repeat (LAT + 2) tick();
    for (int p = 0; p < 2; p++) begin
      while ((p == 0) ? (i_exp.size() > 0) : (d_exp.size() > 0)) begin
        if (p == 0) e = i_exp.pop_front(); else e = d_exp.pop_front();
        checks++;
        if ((p == 0) ? (i_obs.size() == 0) : (d_obs.size() == 0)) begin
          failures++;
          $display("FAIL range port%0d ack missing, required cyc=%0d data=%h err=%b", p, e.cyc, e.data, e.err);
        end else begin
          if (p == 0) o = i_obs.pop_front(); else o = d_obs.pop_front();
          if (o.cyc !== e.cyc || o.err !== e.err || (e.chk && o.data !== e.data)) begin
            failures++;
            $display("FAIL range port%0d got cyc=%0d err=%b data=%h required cyc=%0d err=%b data=%h",
                     p, o.cyc, o.err, o.data, e.cyc, e.err, e.data);
          end
        end
      end
      checks++;
      if ((p == 0) ? (i_obs.size() != 0) : (d_obs.size() != 0)) begin
        failures++;
        $display("FAIL range port%0d extra acks got %0d required 0", p, (p == 0) ? i_obs.size() : d_obs.size());
        if (p == 0) i_obs.delete(); else d_obs.delete();
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    obs_t o;
    logic [31:0] full_exp, part_exp;
`ifdef OTTER_MEM_COLLISION_FWD_EN
    full_exp = 32'h12345678;
    part_exp = 32'hCDEF5678;
`else
    full_exp = 32'hAAAAAAAA;
    part_exp = 32'h12345678;
`endif
    dmem_op(1'b0, 1'b1, 4'hF, 32'h1080, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1080, full_exp, 1'b0);
    dmem_op(1'b0, 1'b1, 4'hF, 32'h1080, 32'h12345678, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1080, 32'h12345678, 1'b0); tick();
    imem_rd(32'h1080, part_exp, 1'b0);
    dmem_op(1'b0, 1'b1, 4'b1100, 32'h1080, 32'hCDEF0000, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1080, 32'hCDEF5678, 1'b0); tick();
    repeat (LAT + 2) tick();
    for (int p = 0; p < 2; p++) begin
      while ((p == 0) ? (i_exp.size() > 0) : (d_exp.size() > 0)) begin
        if (p == 0) e = i_exp.pop_front(); else e = d_exp.pop_front();
        checks++;
        if ((p == 0) ? (i_obs.size() == 0) : (d_obs.size() == 0)) begin
          failures++;
          $display("FAIL collision port%0d ack missing, required cyc=%0d data=%h err=%b", p, e.cyc, e.data, e.err);
        end else begin
          if (p == 0) o = i_obs.pop_front(); else o = d_obs.pop_front();
          if (o.cyc !== e.cyc || o.err !== e.err || (e.chk && o.data !== e.data)) begin
            failures++;
            $display("FAIL collision port%0d got cyc=%0d err=%b data=%h required cyc=%0d err=%b data=%h",
                     p, o.cyc, o.err, o.data, e.cyc, e.err, e.data);
          end
        end
      end
      checks++;
      if ((p == 0) ? (i_obs.size() != 0) : (d_obs.size() != 0)) begin
        failures++;
        $display("FAIL collision port%0d extra acks got %0d required 0", p, (p == 0) ? i_obs.size() : d_obs.size());
        if (p == 0) i_obs.delete(); else d_obs.delete();
      end
    end
  endtask

  task automatic test_reset_flush();
    exp_t e;
    obs_t o;
    bus.i_dmem_we = 1'b1; bus.i_dmem_sel = 4'hF; bus.i_dmem_addr = 32'h10C0;
    bus.i_dmem_w_data = 32'h5A5A5A5A;
    bus.i_imem_req = 1'b1; bus.i_imem_addr = 32'h1040;
    tick();
    bus.i_imem_req = 1'b1; bus.i_imem_addr = 32'h1040;
    bus.i_dmem_re = 1'b1; bus.i_dmem_addr = 32'h1040;
    tick();
    bus.i_imem_req = 1'b1; bus.i_imem_addr = 32'h1040;
    bus.i_dmem_re = 1'b1; bus.i_dmem_addr = 32'h1040;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks += 6;
    if (bus.o_imem_ack !== 1'b0) begin failures++; $display("FAIL flush imem_ack got %b required 0", bus.o_imem_ack); end
    if (bus.o_imem_err !== 1'b0) begin failures++; $display("FAIL flush imem_err got %b required 0", bus.o_imem_err); end
    if (bus.o_imem_r_data !== 32'h0) begin failures++; $display("FAIL flush imem_r_data got %h required 0", bus.o_imem_r_data); end
    if (bus.o_dmem_ack !== 1'b0) begin failures++; $display("FAIL flush dmem_ack got %b required 0", bus.o_dmem_ack); end
    if (bus.o_dmem_err !== 1'b0) begin failures++; $display("FAIL flush dmem_err got %b required 0", bus.o_dmem_err); end
    if (bus.o_dmem_r_data !== 32'h0) begin failures++; $display("FAIL flush dmem_r_data got %h required 0", bus.o_dmem_r_data); end
    repeat (5) tick();
    checks += 2;
    if (i_obs.size() != 0) begin failures++; $display("FAIL flush imem acks got %0d required 0", i_obs.size()); i_obs.delete(); end
    if (d_obs.size() != 0) begin failures++; $display("FAIL flush dmem acks got %0d required 0", d_obs.size()); d_obs.delete(); end
    dmem_op(1'b1, 1'b0, 4'h0, 32'h10C0, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b1); tick();
    repeat (LAT + 2) tick();
    while (d_exp.size() > 0) begin
      e = d_exp.pop_front();
      checks++;
      if (d_obs.size() == 0) begin
        failures++;
        $display("FAIL flush_commit ack missing, required cyc=%0d data=%h", e.cyc, e.data);
      end else begin
        o = d_obs.pop_front();
        if (o.cyc !== e.cyc || o.err !== e.err || o.data !== e.data) begin
          failures++;
          $display("FAIL flush_commit got cyc=%0d err=%b data=%h required cyc=%0d err=%b data=%h",
                   o.cyc, o.err, o.data, e.cyc, e.err, e.data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    dmem_op(1'b0, 1'b1, 4'hF, 32'h1100, 32'h0BADF00D, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1100, 32'h0BADF00D, 1'b0);
    dmem_op(1'b1, 1'b1, 4'hF, 32'h1100, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0); tick();
    imem_rd(32'h1100, 32'h0BADF00D, 1'b0);
    dmem_op(1'b1, 1'b0, 4'h0, 32'h1100, 32'h0, 32'h0BADF00D, 1'b0, 1'b1); tick();
    dmem_op(1'b0, 1'b1, 4'hF, 32'h1104, 32'h01020304, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1100, 32'h0BADF00D, 1'b0);
    dmem_op(1'b1, 1'b0, 4'h0, 32'h1104, 32'h0, 32'h01020304, 1'b0, 1'b1); tick();
    dmem_op(1'b0, 1'b1, 4'b1100, 32'h1104, 32'hAABB0000, 32'h0, 1'b0, 1'b0); tick();
    imem_rd(32'h1104, 32'hAABB0304, 1'b0);
    dmem_op(1'b1, 1'b0, 4'h0, 32'h1104, 32'h0, 32'hAABB0304, 1'b0, 1'b1); tick();
    dmem_op(1'b0, 1'b1, 4'b0001, 32'h1104, 32'h000000EE, 32'h0, 1'b0, 1'b0); tick();
    dmem_op(1'b1, 1'b0, 4'h0, 32'h1104, 32'h0, 32'hAABB03EE, 1'b0, 1'b1); tick();
    repeat (LAT + 2) tick();
    for (int p = 0; p < 2; p++) begin
      while ((p == 0) ? (i_exp.size() > 0) : (d_exp.size() > 0)) begin
        if (p == 0) e = i_exp.pop_front(); else e = d_exp.pop_front();
        checks++;
        if ((p == 0) ? (i_obs.size() == 0) : (d_obs.size() == 0)) begin
          failures++;
          $display("FAIL back_to_back port%0d ack missing, required cyc=%0d data=%h err=%b", p, e.cyc, e.data, e.err);
        end else begin
          if (p == 0) o = i_obs.pop_front(); else o = d_obs.pop_front();
          if (o.cyc !== e.cyc || o.err !== e.err || (e.chk && o.data !== e.data)) begin
            failures++;
            $display("FAIL back_to_back port%0d got cyc=%0d err=%b data=%h required cyc=%0d err=%b data=%h",
                     p, o.cyc, o.err, o.data, e.cyc, e.err, e.data);
          end
        end
      end
      checks++;
      if ((p == 0) ? (i_obs.size() != 0) : (d_obs.size() != 0)) begin
        failures++;
        $display("FAIL back_to_back port%0d extra acks got %0d required 0", p, (p == 0) ? i_obs.size() : d_obs.size());
        if (p == 0) i_obs.delete(); else d_obs.delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_byte_write();
    test_range();
    test_collision();
    test_reset_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
